// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide engine and its decoder-side users.
package mips_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] FN_MULT = 6'd24;
  localparam logic [5:0] FN_DIV  = 6'd26;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } md_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Mul/Div strobe, operand, MTHI/MTLO and HI/LO result bundle between decode/EX and the engine.
interface muldiv_unit_if import mips_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start_mul;
  logic             start_div;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_mul, start_div, src_a, src_b, hi_we, lo_we, wdata,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start_mul, start_div, src_a, src_b, hi_we, lo_we, wdata,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: absolute value at start, sign restoration at commit.
module muldiv_sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] value,
  input  logic         negate,
  output logic [N-1:0] result
);

  assign result = negate ? (~value + N'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) engine with HI/LO registers.
module muldiv_unit import mips_pkg::*; #(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  md_state_t          state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   a_raw;
  logic               sign_a, sign_b, is_div, div_zero;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               start_any;
  logic               load, step, commit;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, rem_shift, rem_diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed, rem_signed;
  logic [WIDTH-1:0]   result_hi, result_lo;

  assign start_any = bus.start_mul | bus.start_div;

  muldiv_sign_fix #(.N(WIDTH)) u_abs_a (
    .value (bus.src_a), .negate(bus.src_a[WIDTH-1]), .result(abs_a)
  );
  muldiv_sign_fix #(.N(WIDTH)) u_abs_b (
    .value (bus.src_b), .negate(bus.src_b[WIDTH-1]), .result(abs_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_any) next_state = CALC;
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    case (state)
      IDLE:    load   = start_any;
      CALC:    step   = 1'b1;
      DONE:    commit = 1'b1;
      default: ;
    endcase
  end

  // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, operand};
    if (is_div) begin
      if (!rem_diff[WIDTH]) acc_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end else begin
      acc_step = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      a_raw    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      a_raw    <= bus.src_a;
      sign_a   <= bus.src_a[WIDTH-1];
      sign_b   <= bus.src_b[WIDTH-1];
      is_div   <= ~bus.start_mul;
      div_zero <= (bus.src_b == '0);
      if (bus.start_mul) begin
        acc     <= {{WIDTH{1'b0}}, abs_b};
        operand <= abs_a;
      end else begin
        acc     <= {{WIDTH{1'b0}}, abs_a};
        operand <= abs_b;
      end
    end else if (step) begin
      acc <= acc_step;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Quotient follows sign(a)^sign(b); remainder follows the dividend
  muldiv_sign_fix #(.N(2*WIDTH)) u_fix_prod (
    .value (acc), .negate(sign_a ^ sign_b), .result(prod_signed)
  );
  muldiv_sign_fix #(.N(WIDTH)) u_fix_quo (
    .value (acc[WIDTH-1:0]), .negate(sign_a ^ sign_b), .result(quo_signed)
  );
  muldiv_sign_fix #(.N(WIDTH)) u_fix_rem (
    .value (acc[2*WIDTH-1:WIDTH]), .negate(sign_a), .result(rem_signed)
  );

  always_comb begin
    if (!is_div) begin
      result_hi = prod_signed[2*WIDTH-1:WIDTH];
      result_lo = prod_signed[WIDTH-1:0];
    end else if (div_zero) begin
      result_hi = a_raw;
      result_lo = '1;
    end else begin
      result_hi = rem_signed;
      result_lo = quo_signed;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (next_state != IDLE);
      done_q <= commit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= result_hi;
      lo_q <= result_lo;
    end else begin
      if (bus.hi_we) hi_q <= bus.wdata;
      if (bus.lo_we) lo_q <= bus.wdata;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = busy_q | start_any;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative signed multiply/divide engine with HI/LO result registers; sits in the EX stage and serves as the execution-side responder to the Mul/Div strobes raised by the instruction decoder.
- Accepts one operation at a time and holds the pipeline through `stall` until the result is committed to HI/LO.
- MFHI/MFLO read `hi`/`lo` directly.
- MTHI/MTLO write HI/LO through dedicated write enables.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits, product is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start_mul  in  1  Mul strobe from decode (funct 24, MULT), EX-stage qualified
- start_div  in  1  Div strobe from decode (funct 26, DIV), EX-stage qualified
- src_a  in  WIDTH  rs operand (multiplicand / dividend)
- src_b  in  WIDTH  rt operand (multiplier / divisor)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  registered; high while an operation is in flight
- stall  out  1  combinational: busy | start_mul | start_div
- done  out  1  registered one-cycle pulse when HI/LO are committed
- hi  out  WIDTH  HI register (product[2W-1:W] / remainder)
- lo  out  WIDTH  LO register (product[W-1:0] / quotient)

Behaviour:
- Reset (rst_n==0 at a clk edge) takes priority over everything:
  - state=IDLE; busy=0, done=0, hi=0, lo=0; counter and datapath cleared.
  - Reset during CALC aborts the operation with no HI/LO update.
- States:
  - IDLE -> CALC on start_mul|start_div.
  - CALC -> CALC while cnt != WIDTH-1.
  - CALC -> DONE when cnt == WIDTH-1.
  - DONE -> IDLE unconditionally.
- Start acceptance (IDLE only):
  - Latch |src_a|, |src_b|, sign flags, op type, divide-by-zero flag (src_b==0); cnt=0; busy=1 next cycle.
  - start_mul and start_div together: multiply wins.
  - Start while busy is ignored; decode is already stalled.
- Multiply: unsigned shift-add, one multiplier bit per cycle, WIDTH cycles. In DONE, negate the 2W-bit magnitude if the operand signs differ.
- Divide: restoring, one quotient bit per cycle, WIDTH cycles. In DONE:
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Divide corner cases:
  - Divisor zero: full latency kept; result forced to HI=src_a (as latched), LO={WIDTH{1'b1}}.
  - Overflow (-2^(W-1) / -1): LO=0x8000_0000, HI=0 for W=32 (two's-complement wrap, no trap).
- DONE cycle: HI/LO written, done=1 for exactly one cycle. busy drops to 0 on the edge leaving DONE.
- Latency: start sampled at edge E0, HI/LO valid and done=1 after edge E0+WIDTH+1. That is 34 edges for W=32; busy is high for WIDTH+1 cycles.
- `stall` is high in the start cycle and every busy cycle. It is low in the cycle after DONE, when the dependent MFHI/MFLO proceeds.
- hi_we/lo_we:
  - In IDLE: write wdata on that edge.
  - During CALC: also written, but overwritten by DONE.
  - Same edge as DONE: the DONE result wins.
  - hi_we and lo_we both high: both registers take wdata.

Decomposition:
- Shared package `mips_pkg`:
  - funct constants FN_MULT=6'd24, FN_DIV=6'd26.
  - State enum {IDLE, CALC, DONE}.
  - WIDTH default.
- One natural sub-module: `muldiv_sign_fix`, the combinational magnitude/negate helper. It is used at both the start (abs) and DONE (result sign correction) points.
- The iteration datapath stays in muldiv_unit.

Test Plan:
- Multiply, signs differ: start_mul, a=7, b=-3 -> done after 34 edges; HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; busy high 33 cycles; stall high in the start cycle.
- Divide, mixed signs: start_div, a=-17, b=5 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFE (-2).
- Divide by zero and overflow:
  - a=0x1234, b=0 -> HI=0x1234, LO=0xFFFF_FFFF after 34 edges.
  - a=0x8000_0000, b=0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- Ignored start and simultaneous strobes:
  - start_div pulsed mid-CALC of a multiply -> ignored; result unchanged.
  - start_mul and start_div together with a=6, b=4 -> multiply: HI=0, LO=24.
- Reset mid-op: rst_n=0 at cycle 10 of CALC -> next edge busy=0, done=0, hi=lo=0; a following start_mul 3*5 yields LO=15.
- MTHI/MTLO:
  - hi_we=1, wdata=0xA5A5 while IDLE -> hi=0xA5A5 next cycle.
  - lo_we on the same edge as DONE -> lo holds the DONE result.
